// File: rtl/disp_scan_if.sv
// disp_scan_if: bundle between the digit-scan controller and its consumer.
//   en    - scan enable; the consumer drives it into the controller
//   sel   - registered 2-bit digit select that feeds the downstream 4:1 digit mux
//   an    - active-low anode enables, decoded combinationally from registered state
//   frame - one-cycle pulse at the start of each new frame
// The slave modport is the controller side. The master modport is the consumer side.
interface disp_scan_if;
  logic       en;
  logic [1:0] sel;
  logic [3:0] an;
  logic       frame;

  modport master (output en, input  sel, input  an, input  frame);
  modport slave  (input  en, output sel, output an, output frame);
endinterface

// File: rtl/disp_scan.sv
// disp_scan: digit-scan controller for a 4-digit multiplexed display.
// Each digit gets a slot of DIV enabled cycles. The first DEAD cycles of a slot
// are blanked while the mux output settles. When all four digits have been
// scanned, a one-cycle frame strobe is raised.
// Ports:
//   clk   - system clock; all state changes on the rising edge
//   reset - synchronous, active-high reset; takes priority over en
//   bus   - disp_scan_if.slave carrying en (in) and sel, an, frame (out)
module disp_scan #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned DIV   = 50000,
  parameter int unsigned DEAD  = 4
) (
  input  logic          clk,
  input  logic          reset,
  disp_scan_if.slave    bus
);

  localparam logic [DIV_W-1:0] CNT_MAX  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_CNT = DIV_W'(DEAD);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             frame_q, frame_d;
  logic             dead_c;
  logic [3:0]       an_c;

  // Slot counter, digit select and frame strobe next-state
  always_comb begin
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    frame_d = 1'b0;
    if (bus.en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        sel_d   = sel_q + 2'd1;
        // The wrap out of digit 3 completes a frame
        frame_d = (sel_q == 2'd3);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
    end
  end

  // Dead-time window. With DEAD=0 there is no window, so no compare is built.
  if (DEAD == 0) begin : g_no_dead
    assign dead_c = 1'b0;
  end else begin : g_dead
    assign dead_c = (cnt_q < DEAD_CNT);
  end

  // Anode decode. Blank during reset, while disabled, or inside the dead-time window.
  always_comb begin
    an_c = 4'b1111;
    if (!reset && bus.en && !dead_c) begin
      an_c = ~(4'b0001 << sel_q);
    end
  end

  assign bus.sel   = sel_q;
  assign bus.frame = frame_q;
  assign bus.an    = an_c;

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: drives two disp_scan instances from the same reset and en.
//   Instance A uses DIV=8 and DEAD=2. Instance B uses DIV=4 and DEAD=0.
// Directed phases come first, then a random run. Each instance is checked
// against a model that tracks only the number of enabled cycles since reset.
module tb_disp_scan;

  localparam int DIV_A  = 8;
  localparam int DEAD_A = 2;
  localparam int DIV_B  = 4;
  localparam int DEAD_B = 0;

  logic clk;
  logic reset;
  logic en;

  int total = 0;
  int bad   = 0;

  // Model state: enabled edges since reset, and whether the last edge was enabled
  int n_m   = 0;
  bit last_en_m = 1'b0;

  disp_scan_if ifa ();
  disp_scan_if ifb ();

  assign ifa.en = en;
  assign ifb.en = en;

  disp_scan #(.DIV_W(16), .DIV(DIV_A), .DEAD(DEAD_A)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  disp_scan #(.DIV_W(16), .DIV(DIV_B), .DEAD(DEAD_B)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (n=%0d t=%0t)", tag, got, exp, n_m, $time);
    end
  endtask

  function automatic logic [1:0] sel_exp(input int n, input int div);
    return 2'((n / div) % 4);
  endfunction

  function automatic logic [3:0] an_exp(input int n, input int div, input int dead,
                                        input bit r, input bit e);
    logic [3:0] onehot;
    if (r || !e || ((n % div) < dead)) return 4'b1111;
    onehot = 4'b0001 << sel_exp(n, div);
    return ~onehot;
  endfunction

  function automatic logic frame_exp(input int n, input int div, input bit last_en);
    return last_en && (n != 0) && ((n % (4 * div)) == 0);
  endfunction

  // One cycle: apply inputs, check both instances, then advance the model on the edge
  task automatic step(input bit r, input bit e);
    @(negedge clk);
    reset = r;
    en    = e;
    #1;
    chk("a_sel",   32'(ifa.sel),   32'(sel_exp(n_m, DIV_A)));
    chk("a_an",    32'(ifa.an),    32'(an_exp(n_m, DIV_A, DEAD_A, r, e)));
    chk("a_frame", 32'(ifa.frame), 32'(frame_exp(n_m, DIV_A, last_en_m)));
    chk("b_sel",   32'(ifb.sel),   32'(sel_exp(n_m, DIV_B)));
    chk("b_an",    32'(ifb.an),    32'(an_exp(n_m, DIV_B, DEAD_B, r, e)));
    chk("b_frame", 32'(ifb.frame), 32'(frame_exp(n_m, DIV_B, last_en_m)));
    if (!r && e) chk("b_never_blank", 32'(ifb.an == 4'b1111), 32'd0);
    @(posedge clk);
    if (r) begin
      n_m = 0;
      last_en_m = 1'b0;
    end else if (e) begin
      n_m++;
      last_en_m = 1'b1;
    end else begin
      last_en_m = 1'b0;
    end
  endtask

  task automatic run(input int cycles, input bit r, input bit e);
    for (int i = 0; i < cycles; i++) step(r, e);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    @(posedge clk);

    // Reset held with en high, then release and free-run past the first frame
    run(3, 1'b1, 1'b1);
    run(33, 1'b0, 1'b1);
    // Advance to sel=2, cnt=5 on A, hold for 10 cycles, then resume into the next slot
    run(20, 1'b0, 1'b1);
    run(10, 1'b0, 1'b0);
    run(4, 1'b0, 1'b1);
    // Advance to sel=3, cnt=6 on A and reset there, aborting the frame
    run(5, 1'b0, 1'b1);
    run(1, 1'b1, 1'b1);
    run(40, 1'b0, 1'b1);
    // Advance to sel=3, cnt=7 on A, hold on the wrap point, then resume
    run(23, 1'b0, 1'b1);
    run(4, 1'b0, 1'b0);
    run(3, 1'b0, 1'b1);

    // Random enable with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
